// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: bimodal table of 2-bit counters, next-PC select, mispredict flush.
// Optional table build guarded by macro BRANCH_PREDICTOR_BHT_EN; without it the predictor is static not-taken.
module branch_predictor #(
    parameter int         IDX_BITS   = 4,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        MemStall_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic        resolve_valid_i,
    input  logic [31:0] resolve_pc_i,
    input  logic        resolve_taken_i,
    input  logic        resolve_pred_i,
    input  logic [31:0] resolve_target_i,
    output logic [31:0] pc_next_o,
    output logic        pred_taken_o,
    output logic        flush_o,
    output logic [31:0] branch_cnt_o,
    output logic [31:0] mispred_cnt_o
);

    logic        is_branch;
    logic [31:0] imm_b;
    logic [31:0] pred_target;
    logic [31:0] pc_seq;
    logic        mispredict;
    logic        update_en;

    assign is_branch   = (inst_i[6:0] == 7'b1100011);
    assign imm_b       = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign pred_target = pc_i + imm_b;
    assign pc_seq      = pc_i + 32'd4;
    assign mispredict  = resolve_valid_i && (resolve_taken_i != resolve_pred_i);

    // resolve_valid_i qualifies one resolution per cycle; it is consumed only when
    // neither stall is active, so a resolution held across a stall is applied once.
    assign update_en = resolve_valid_i && !stall_i && !MemStall_i;
    assign flush_o   = mispredict && !stall_i && !MemStall_i;

`ifdef BRANCH_PREDICTOR_BHT_EN
    localparam int ENTRIES = 1 << IDX_BITS;

    logic [1:0]          bht [ENTRIES];
    logic [IDX_BITS-1:0] look_idx;
    logic [IDX_BITS-1:0] upd_idx;
    logic [1:0]          upd_cur;
    logic [1:0]          upd_next;
    logic                unused_bits;

    assign look_idx    = pc_i[IDX_BITS+1:2];
    assign upd_idx     = resolve_pc_i[IDX_BITS+1:2];
    assign upd_cur     = bht[upd_idx];
    assign unused_bits = ^{inst_i[24:12]};

    // Lookup reads the registered table, so a same-cycle update is seen next cycle.
    assign pred_taken_o = is_branch && bht[look_idx][1];

    always_comb begin
        upd_next = upd_cur;
        if (resolve_taken_i) begin
            if (upd_cur != 2'b11) upd_next = upd_cur + 2'd1;
        end else begin
            if (upd_cur != 2'b00) upd_next = upd_cur - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bht <= '{default: INIT_STATE};
        end else if (update_en) begin
            bht[upd_idx] <= upd_next;
        end
    end
`else
    logic unused_bits;

    assign unused_bits  = ^{inst_i[24:12], is_branch};
    assign pred_taken_o = 1'b0;
`endif

    always_comb begin
        if (mispredict) begin
            pc_next_o = resolve_taken_i ? resolve_target_i : (resolve_pc_i + 32'd4);
        end else if (pred_taken_o) begin
            pc_next_o = pred_target;
        end else begin
            pc_next_o = pc_seq;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt_o  <= 32'd0;
            mispred_cnt_o <= 32'd0;
        end else if (update_en) begin
            branch_cnt_o <= branch_cnt_o + 32'd1;
            if (mispredict) mispred_cnt_o <= mispred_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reset, training, stalls, saturation, bypass order, wrap.
// Expected prediction bits follow whether BRANCH_PREDICTOR_BHT_EN is defined.
module tb_branch_predictor;

`ifdef BRANCH_PREDICTOR_BHT_EN
    localparam bit BHT = 1'b1;
`else
    localparam bit BHT = 1'b0;
`endif

    localparam logic [31:0] BEQ_P16 = 32'h0000_0863;  // beq x0,x0,+16
    localparam logic [31:0] BEQ_M8  = 32'hFE00_0CE3;  // beq x0,x0,-8
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        mem_stall;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        r_valid;
    logic [31:0] r_pc;
    logic        r_taken;
    logic        r_pred;
    logic [31:0] r_target;
    logic [31:0] pc_next;
    logic        pred_taken;
    logic        flush;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int errors = 0;
    int checks = 0;

    branch_predictor dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .stall_i          (stall),
        .MemStall_i       (mem_stall),
        .pc_i             (pc),
        .inst_i           (inst),
        .resolve_valid_i  (r_valid),
        .resolve_pc_i     (r_pc),
        .resolve_taken_i  (r_taken),
        .resolve_pred_i   (r_pred),
        .resolve_target_i (r_target),
        .pc_next_o        (pc_next),
        .pred_taken_o     (pred_taken),
        .flush_o          (flush),
        .branch_cnt_o     (branch_cnt),
        .mispred_cnt_o    (mispred_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drivers
    task automatic fetch(input logic [31:0] p, input logic [31:0] i);
        pc   = p;
        inst = i;
    endtask

    task automatic resolve(input logic v, input logic [31:0] p, input logic t,
                           input logic pr, input logic [31:0] tg);
        r_valid  = v;
        r_pc     = p;
        r_taken  = t;
        r_pred   = pr;
        r_target = tg;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] b, input logic [31:0] m);
        check({tag, "_branch_cnt"}, branch_cnt, b);
        check({tag, "_mispred_cnt"}, mispred_cnt, m);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; mem_stall = 1'b0;
        fetch(32'h0, NOP);
        resolve(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state: BEQ at 0x40 not predicted
        fetch(32'h40, BEQ_P16);
        #1;
        check("rst_pred", {31'd0, pred_taken}, 32'd0);
        check("rst_pc_next", pc_next, 32'h44);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check_cnt("rst", 32'd0, 32'd0);

        // Train entry 0 taken twice via mispredicts
        resolve(1'b1, 32'h40, 1'b1, 1'b0, 32'h50);
        #1;
        check("train1_flush", {31'd0, flush}, 32'd1);
        check("train1_pc_next", pc_next, 32'h50);
        check("train1_pred", {31'd0, pred_taken}, 32'd0);
        tick();
        check("train2_pred", {31'd0, pred_taken}, {31'd0, BHT});
        check("train2_flush", {31'd0, flush}, 32'd1);
        check_cnt("train1", 32'd1, 32'd1);
        tick();
        resolve(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check_cnt("train2", 32'd2, 32'd2);
        check("trained_pred", {31'd0, pred_taken}, {31'd0, BHT});
        check("trained_pc_next", pc_next, BHT ? 32'h50 : 32'h44);

        // Hazard stall then cache stall on a held resolution at 0x44 (entry 1)
        fetch(32'h44, BEQ_P16);
        resolve(1'b1, 32'h44, 1'b1, 1'b0, 32'h100);
        stall = 1'b1;
        #1;
        check("stall_flush", {31'd0, flush}, 32'd0);
        check("stall_pc_next", pc_next, 32'h100);
        tick();
        check_cnt("stall", 32'd2, 32'd2);
        stall = 1'b0;
        mem_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("mstall_flush", {31'd0, flush}, 32'd0);
            tick();
            check_cnt("mstall", 32'd2, 32'd2);
        end
        mem_stall = 1'b0;
        #1;
        check("release_flush", {31'd0, flush}, 32'd1);
        tick();
        check_cnt("release", 32'd3, 32'd3);
        resolve(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check("once_pred", {31'd0, pred_taken}, {31'd0, BHT});
        // One not-taken step must drop entry 1 back below taken (10 -> 01)
        resolve(1'b1, 32'h44, 1'b0, 1'b1, 32'h0);
        #1;
        check("nt_pc_next", pc_next, 32'h48);
        tick();
        resolve(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check_cnt("nt", 32'd4, 32'd4);
        check("once_nt_pred", {31'd0, pred_taken}, 32'd0);

        // Saturate entry 0 down: 11 -> 10 -> 01 -> 00 -> 00
        fetch(32'h40, BEQ_P16);
        resolve(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);
        tick();
        check("sat1_pred", {31'd0, pred_taken}, {31'd0, BHT});
        tick();
        check("sat2_pred", {31'd0, pred_taken}, 32'd0);
        tick();
        check("sat3_pred", {31'd0, pred_taken}, 32'd0);
        tick();
        check("sat4_pred", {31'd0, pred_taken}, 32'd0);
        check_cnt("sat", 32'd8, 32'd8);
        // Correct taken resolution: no flush, no mispredict count, 00 -> 01
        resolve(1'b1, 32'h40, 1'b1, 1'b1, 32'h50);
        #1;
        check("ok_flush", {31'd0, flush}, 32'd0);
        check("ok_pc_next", pc_next, 32'h44);
        tick();
        resolve(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check_cnt("ok", 32'd9, 32'd8);
        check("sat_floor_pred", {31'd0, pred_taken}, 32'd0);

        // Same-cycle lookup and update at 0x80 (index 0, entry 01)
        fetch(32'h80, BEQ_P16);
        resolve(1'b1, 32'h80, 1'b1, 1'b0, 32'h200);
        #1;
        check("same_pred", {31'd0, pred_taken}, 32'd0);
        check("same_pc_next", pc_next, 32'h200);
        tick();
        resolve(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check("same_next_pred", {31'd0, pred_taken}, {31'd0, BHT});
        check("same_next_pc", pc_next, BHT ? 32'h90 : 32'h84);
        check_cnt("same", 32'd10, 32'd9);

        // Backward target and wrap-around
        fetch(32'h40, BEQ_M8);
        #1;
        check("back_pc_next", pc_next, BHT ? 32'h38 : 32'h44);
        fetch(32'hFFFF_FFFC, NOP);
        #1;
        check("wrap_pred", {31'd0, pred_taken}, 32'd0);
        check("wrap_pc_next", pc_next, 32'h0);
        resolve(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0);
        #1;
        check("wrap_resolve_pc_next", pc_next, 32'h0);

        // Reset overrides a simultaneous update
        fetch(32'h40, BEQ_P16);
        resolve(1'b1, 32'h40, 1'b1, 1'b0, 32'h50);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        resolve(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check_cnt("rst_upd", 32'd0, 32'd0);
        check("rst_upd_pred", {31'd0, pred_taken}, 32'd0);
        check("rst_upd_pc_next", pc_next, 32'h44);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
